layer_seq: RTL and testbench

// Layer sequencer for batch_ctrl. Holds a descriptor table of up to MAX_LAYERS layers and, per layer:

---
 rtl/layer_seq.sv | 197 +++++++++++++++++++
 tb/tb_layer_seq.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq.sv
// Layer sequencer for batch_ctrl: walks a descriptor table, driving dims and the
// weight-write / bias-write / run phases, each ended by counting stream handshakes.
module layer_seq #(
    parameter int MAX_LAYERS = 8,
    parameter int LW         = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [LW+1:0] cfg_addr,
    input  logic [31:0]   cfg_wdata,
    input  logic [LW-1:0] num_layers,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] layer_idx,
    output logic          run,
    output logic          wwrite,
    output logic          bwrite,
    output logic          backprop,
    output logic [11:0]   ss,
    output logic [11:0]   ds,
    output logic [3:0]    id,
    output logic [3:0]    od,
    output logic [9:0]    fs,
    output logic [9:0]    ks,
    input  logic          src_valid,
    input  logic          src_ready,
    input  logic          dst_valid,
    input  logic          dst_ready
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_LOAD = 4'd1;
    localparam logic [3:0] S_CALC = 4'd2;
    localparam logic [3:0] S_WWR  = 4'd3;
    localparam logic [3:0] S_GAP1 = 4'd4;
    localparam logic [3:0] S_BWR  = 4'd5;
    localparam logic [3:0] S_GAP2 = 4'd6;
    localparam logic [3:0] S_RUN  = 4'd7;
    localparam logic [3:0] S_GAP3 = 4'd8;
    localparam logic [3:0] S_NEXT = 4'd9;
    localparam logic [3:0] S_DONE = 4'd10;

    // Weight beats: backprop streams the transposed kernel set, forward the FC matrix.
    function automatic logic [18:0] calc_wbeats(input logic bp_i, input logic [3:0] id_i,
                                                input logic [3:0] od_i, input logic [9:0] ks_i,
                                                input logic [9:0] fs_i);
        logic [18:0] id1, od1, ks1, fs1;
        id1 = {15'd0, id_i} + 19'd1;
        od1 = {15'd0, od_i} + 19'd1;
        ks1 = {9'd0, ks_i} + 19'd1;
        fs1 = {9'd0, fs_i} + 19'd1;
        return bp_i ? (id1 * od1 * ks1) : (od1 * fs1);
    endfunction

    function automatic logic [27:0] calc_rbeats(input logic [15:0] ns_i, input logic [11:0] ds_i);
        logic [27:0] ns_x, ds1;
        ns_x = {12'd0, ns_i};
        ds1  = {16'd0, ds_i} + 28'd1;
        return ns_x * ds1;
    endfunction

    logic [31:0] tbl_w0 [MAX_LAYERS];
    logic [20:0] tbl_w1 [MAX_LAYERS];
    logic [15:0] tbl_w2 [MAX_LAYERS];

    logic [3:0]  state, state_nx;
    logic [15:0] nsamp_q;
    logic [18:0] tgt_w;
    logic [4:0]  tgt_b;
    logic [27:0] tgt_r;
    logic [27:0] beat_cnt;
    logic [27:0] phase_tgt;
    logic        phase_beat;
    logic        phase_last;
    logic        in_phase;
    logic        unused_src_ready;

    assign unused_src_ready = src_ready;

    // Descriptor table is plain storage: no reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (cfg_we && state == S_IDLE) begin
            case (cfg_addr[1:0])
                2'd0:    tbl_w0[cfg_addr[LW+1:2]] <= cfg_wdata;
                2'd1:    tbl_w1[cfg_addr[LW+1:2]] <= cfg_wdata[20:0];
                2'd2:    tbl_w2[cfg_addr[LW+1:2]] <= cfg_wdata[15:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        phase_beat = 1'b0;
        phase_tgt  = '0;
        case (state)
            S_WWR: begin
                phase_beat = src_valid;
                phase_tgt  = {9'd0, tgt_w};
            end
            S_BWR: begin
                phase_beat = src_valid;
                phase_tgt  = {23'd0, tgt_b};
            end
            S_RUN: begin
                phase_beat = dst_valid & dst_ready;
                phase_tgt  = tgt_r;
            end
            default: ;
        endcase
        in_phase   = (state == S_WWR) || (state == S_BWR) || (state == S_RUN);
        phase_last = phase_beat && ((beat_cnt + 28'd1) == phase_tgt);
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_CALC;
            S_CALC:  state_nx = S_WWR;
            S_WWR:   if (phase_last) state_nx = S_GAP1;
            S_GAP1:  state_nx = backprop ? S_GAP2 : S_BWR;
            S_BWR:   if (phase_last) state_nx = S_GAP2;
            S_GAP2:  state_nx = (tgt_r == 28'd0) ? S_GAP3 : S_RUN;
            S_RUN:   if (phase_last) state_nx = S_GAP3;
            S_GAP3:  state_nx = S_NEXT;
            S_NEXT:  state_nx = (layer_idx == num_layers) ? S_DONE : S_LOAD;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nx = S_IDLE;
    end

    // Control path: state, layer pointer and beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            layer_idx <= '0;
            beat_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                layer_idx <= '0;
            end else if (state == S_NEXT && state_nx == S_LOAD) begin
                layer_idx <= layer_idx + 1'b1;
            end
            // The hitting beat and any gap-state beats never carry into the next phase.
            if (!in_phase || phase_last) begin
                beat_cnt <= '0;
            end else if (phase_beat) begin
                beat_cnt <= beat_cnt + 28'd1;
            end
        end
    end

    // Dims are captured in LOAD only; targets settle in CALC, a cycle ahead of WWR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss       <= '0;
            ds       <= '0;
            id       <= '0;
            od       <= '0;
            fs       <= '0;
            ks       <= '0;
            backprop <= 1'b0;
            nsamp_q  <= '0;
            tgt_w    <= '0;
            tgt_b    <= '0;
            tgt_r    <= '0;
        end else begin
            if (state == S_LOAD) begin
                od       <= tbl_w0[layer_idx][31:28];
                id       <= tbl_w0[layer_idx][27:24];
                ds       <= tbl_w0[layer_idx][23:12];
                ss       <= tbl_w0[layer_idx][11:0];
                backprop <= tbl_w1[layer_idx][20];
                ks       <= tbl_w1[layer_idx][19:10];
                fs       <= tbl_w1[layer_idx][9:0];
                nsamp_q  <= tbl_w2[layer_idx];
            end
            if (state == S_CALC) begin
                tgt_w <= calc_wbeats(backprop, id, od, ks, fs);
                tgt_b <= {1'b0, od} + 5'd1;
                tgt_r <= calc_rbeats(nsamp_q, ds);
            end
        end
    end

    assign busy   = (state != S_IDLE);
    assign done   = (state == S_DONE);
    assign wwrite = (state == S_WWR);
    assign bwrite = (state == S_BWR);
    assign run    = (state == S_RUN);

endmodule

// File: tb/tb_layer_seq.sv
// Self-checking bench for layer_seq: a per-layer phase-list model checked every cycle
// against the DUT mode outputs, dims and beat counts, with directed and random layers.
module tb_layer_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [2:0]  num_layers;
    logic        start, abort;
    logic        busy, done;
    logic [2:0]  layer_idx;
    logic        run, wwrite, bwrite, backprop;
    logic [11:0] ss, ds;
    logic [3:0]  id, od;
    logic [9:0]  fs, ks;
    logic        src_valid, src_ready, dst_valid, dst_ready;

    layer_seq #(.MAX_LAYERS(8), .LW(3)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .num_layers(num_layers), .start(start), .abort(abort), .busy(busy), .done(done),
        .layer_idx(layer_idx), .run(run), .wwrite(wwrite), .bwrite(bwrite), .backprop(backprop),
        .ss(ss), .ds(ds), .id(id), .od(od), .fs(fs), .ks(ks),
        .src_valid(src_valid), .src_ready(src_ready), .dst_valid(dst_valid), .dst_ready(dst_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference descriptor table
    int m_ss[8], m_ds[8], m_id[8], m_od[8], m_fs[8], m_ks[8], m_bp[8], m_ns[8];

    function automatic int m_wbeats(int l);
        return m_bp[l] != 0 ? (m_id[l] + 1) * (m_od[l] + 1) * (m_ks[l] + 1)
                            : (m_od[l] + 1) * (m_fs[l] + 1);
    endfunction

    typedef struct {
        int layer;
        int mode;   // 1 wwrite, 2 bwrite, 3 run
        int tgt;
        int gap;    // idle cycles expected before this phase, 0 = unchecked
    } ph_t;
    ph_t exp_q[$];

    task automatic build_expected(input int nl);
        ph_t e;
        exp_q.delete();
        for (int l = 0; l <= nl; l++) begin
            e.layer = l; e.mode = 1; e.tgt = m_wbeats(l); e.gap = 0;
            exp_q.push_back(e);
            if (m_bp[l] == 0) begin
                e.mode = 2; e.tgt = m_od[l] + 1; e.gap = 1;
                exp_q.push_back(e);
            end
            if (m_ns[l] * (m_ds[l] + 1) > 0) begin
                e.mode = 3; e.tgt = m_ns[l] * (m_ds[l] + 1); e.gap = (m_bp[l] != 0) ? 2 : 1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Per-cycle checker state
    bit chk_en = 0;
    int cur_mode, ph_cnt, ph_tgt, gap, done_cnt;
    bit ph_last, saw_b;
    int meas_w, meas_b, meas_r;

    task automatic chk_reset();
        cur_mode = 0; ph_cnt = 0; ph_tgt = 0; gap = 0; ph_last = 0;
        saw_b = 0; done_cnt = 0; meas_w = -1; meas_b = -1; meas_r = -1;
    endtask

    always @(negedge clk) begin
        int  mode;
        bit  beat;
        ph_t e;
        if (chk_en && rst_n) begin
            check("mode_onehot", 64'($countones({run, wwrite, bwrite}) <= 1), 64'd1);
            mode = run ? 3 : bwrite ? 2 : wwrite ? 1 : 0;
            beat = (mode == 1 || mode == 2) ? src_valid : (mode == 3) ? (dst_valid & dst_ready) : 1'b0;
            if (mode != cur_mode) begin
                if (cur_mode != 0) begin
                    check($sformatf("phase%0d_beats", cur_mode), 64'(ph_cnt), 64'(ph_tgt));
                    check("phase_ends_on_beat", 64'(ph_last), 64'd1);
                    if (cur_mode == 1) meas_w = ph_cnt;
                    if (cur_mode == 2) meas_b = ph_cnt;
                    if (cur_mode == 3) meas_r = ph_cnt;
                    gap = 0;
                end
                if (mode != 0) begin
                    check("phase_expected", 64'(exp_q.size() != 0), 64'd1);
                    ph_tgt = -1;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("phase_layer_mode", {32'(layer_idx), 32'(mode)}, {32'(e.layer), 32'(e.mode)});
                        if (e.gap != 0) check("gap_cycles", 64'(gap), 64'(e.gap));
                        ph_tgt = e.tgt;
                    end
                    ph_cnt = 0;
                end
            end
            if (mode == 0) gap++;
            if (mode != 0) begin
                check("dims", {ss, ds, id, od, fs, ks, backprop},
                      {12'(m_ss[layer_idx]), 12'(m_ds[layer_idx]), 4'(m_id[layer_idx]),
                       4'(m_od[layer_idx]), 10'(m_fs[layer_idx]), 10'(m_ks[layer_idx]),
                       1'(m_bp[layer_idx])});
                check("busy_in_phase", 64'(busy), 64'd1);
                ph_cnt += int'(beat);
                ph_last = beat;
            end
            if (mode == 2) saw_b = 1;
            if (done) begin
                check("done_after_all_phases", 64'(exp_q.size()), 64'd0);
                check("busy_in_done", 64'(busy), 64'd1);
                done_cnt++;
            end
            cur_mode = mode;
        end
    end

    // Random stream handshakes, changed just after each edge
    int src_pct = 100;
    int dst_pct = 70;
    initial begin
        src_valid = 0; src_ready = 0; dst_valid = 0; dst_ready = 0;
        forever begin
            @(posedge clk); #1;
            src_valid = ($urandom_range(99) < src_pct);
            src_ready = ($urandom_range(1) == 1);
            dst_valid = ($urandom_range(99) < dst_pct);
            dst_ready = ($urandom_range(99) < dst_pct) || (dst_pct == 100);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cfg_write(input int l, input int w, input logic [31:0] d);
        cfg_we = 1; cfg_addr = {3'(l), 2'(w)}; cfg_wdata = d;
        tick();
        cfg_we = 0;
    endtask

    task automatic write_layer(input int l, input int ss_v, input int ds_v, input int id_v,
                               input int od_v, input int fs_v, input int ks_v, input int bp_v,
                               input int ns_v);
        cfg_write(l, 0, {4'(od_v), 4'(id_v), 12'(ds_v), 12'(ss_v)});
        cfg_write(l, 1, {11'd0, 1'(bp_v), 10'(ks_v), 10'(fs_v)});
        cfg_write(l, 2, {16'd0, 16'(ns_v)});
        m_ss[l] = ss_v; m_ds[l] = ds_v; m_id[l] = id_v; m_od[l] = od_v;
        m_fs[l] = fs_v; m_ks[l] = ks_v; m_bp[l] = bp_v; m_ns[l] = ns_v;
    endtask

    // Start a sequence, require busy one cycle later, a done pulse within budget, then idle.
    task automatic run_seq(input int nl, input bit with_abort);
        bit seen;
        build_expected(nl);
        chk_reset();
        num_layers = 3'(nl);
        check("idle_before_start", 64'(busy), 64'd0);
        start = 1; abort = with_abort;
        tick();
        start = 0; abort = 0;
        check("busy_after_start", 64'(busy), 64'd1);
        chk_en = 1;
        seen = 0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("seq_done_seen", 64'(seen), 64'd1);
        tick();
        check("busy_after_done", {busy, done}, 2'b00);
        check("done_pulses", 64'(done_cnt), 64'd1);
    endtask

    initial begin
        bit seen;
        rst_n = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0; num_layers = '0;
        start = 0; abort = 0;
        chk_reset();
        tick(3);
        check("reset_outputs", {busy, done, layer_idx, run, wwrite, bwrite, backprop,
                                ss, ds, id, od, fs, ks}, 64'd0);
        rst_n = 1;
        tick(2);

        // 1: forward layer
        write_layer(0, 5, 3, 0, 3, 24, 0, 0, 2);
        cfg_write(0, 3, 32'hFFFF_FFFF);
        run_seq(0, 0);
        check("t1_wbeats", 64'(meas_w), 64'd100);
        check("t1_bbeats", 64'(meas_b), 64'd4);
        check("t1_rbeats", 64'(meas_r), 64'd8);

        // 2: backprop layer, abort+start together in idle (start wins)
        src_pct = 60;
        write_layer(1, 7, 1, 1, 2, 0, 8, 1, 3);
        write_layer(0, 7, 1, 1, 2, 0, 8, 1, 3);
        run_seq(0, 1);
        check("t2_wbeats", 64'(meas_w), 64'd54);
        check("t2_no_bwrite", 64'(saw_b), 64'd0);
        check("t2_rbeats", 64'(meas_r), 64'd6);

        // 3: three random layers, 50% src_valid
        src_pct = 50;
        for (int r = 0; r < 3; r++) begin
            for (int l = 0; l < 3; l++)
                write_layer(l, $urandom_range(4095), $urandom_range(3), $urandom_range(3),
                            $urandom_range(3), $urandom_range(15), $urandom_range(7),
                            $urandom_range(1), $urandom_range(4));
            run_seq(2, 0);
        end

        // 4: abort in RUN after 3 of 8 beats, then restart
        src_pct = 100; dst_pct = 100;
        write_layer(0, 5, 3, 0, 3, 24, 0, 0, 2);
        build_expected(0);
        chk_reset();
        num_layers = 0;
        start = 1; tick(); start = 0;
        chk_en = 1;
        seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            tick();
            if (run) seen = 1;
        end
        check("t4_run_reached", 64'(seen), 64'd1);
        tick(2);
        chk_en = 0;
        abort = 1;
        tick();
        abort = 0;
        check("t4_after_abort", {run, wwrite, bwrite, busy}, 4'b0000);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || busy) seen = 1;
            tick();
        end
        check("t4_no_done_after_abort", 64'(seen), 64'd0);
        dst_pct = 70;
        run_seq(0, 0);
        check("t4_restart_wbeats", 64'(meas_w), 64'd100);

        // 5: cfg write while busy is ignored; start while busy is ignored
        build_expected(0);
        chk_reset();
        num_layers = 0;
        start = 1; tick(); start = 0;
        chk_en = 1;
        tick(4);
        cfg_write(0, 0, {4'd7, 4'd0, 12'd3, 12'd5});
        start = 1; tick(); start = 0;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            if (done) seen = 1;
        end
        check("t5_done_seen", 64'(seen), 64'd1);
        tick();
        check("t5_wbeats_old_od", 64'(meas_w), 64'd100);
        check("t5_done_pulses", 64'(done_cnt), 64'd1);
        run_seq(0, 0);
        check("t5_next_seq_old_od", 64'(meas_w), 64'd100);

        // 6: nsamp=0 skips RUN; async reset mid-WWR
        write_layer(0, 9, 2, 0, 1, 3, 0, 0, 0);
        run_seq(0, 0);
        check("t6_no_run", 64'(meas_r), -64'sd1);
        build_expected(0);
        chk_reset();
        start = 1; tick(); start = 0;
        chk_en = 1;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (wwrite) seen = 1;
        end
        check("t6_wwr_reached", 64'(seen), 64'd1);
        #1;
        chk_en = 0;
        rst_n = 0;
        #1;
        check("t6_async_reset_outputs", {busy, done, layer_idx, run, wwrite, bwrite, backprop,
                                         ss, ds, id, od, fs, ks}, 64'd0);
        tick();
        rst_n = 1;
        tick(2);
        check("t6_idle_after_reset", {busy, done, run, wwrite, bwrite}, 5'd0);
        write_layer(0, 5, 3, 0, 3, 24, 0, 0, 2);
        run_seq(0, 0);
        check("t6_post_reset_rbeats", 64'(meas_r), 64'd8);

        chk_en = 0;
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
